// File: rtl/z_branch_resolver.sv
// Branch resolution tracker: queues predicted branches in fetch order and checks
// each one against execute's outcome, raising a registered flush with the recovery PC.
module z_branch_resolver #(
    parameter int unsigned PC_W  = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    input  logic [PC_W-1:0]            pred_alt_pc,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       flush,
    output logic [PC_W-1:0]            redirect_pc,
    output logic                       upd_valid,
    output logic                       upd_taken,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic [15:0]                mispredict_count,
    output logic                       err_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic              taken_mem [DEPTH];
    logic [PC_W-1:0]   alt_mem   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic              push;
    logic              resolve;
    logic              mismatch;
    logic              underflow;
    logic              head_taken;
    logic [PC_W-1:0]   head_alt_pc;

    assign head_taken  = taken_mem[rd_ptr];
    assign head_alt_pc = alt_mem[rd_ptr];

    always_comb begin
        pred_ready = (inflight < CNT_W'(DEPTH)) && !flush;
        push       = pred_valid && pred_ready;
        resolve    = res_valid && (inflight != '0);
        underflow  = res_valid && (inflight == '0);
        mismatch   = resolve && (res_taken != head_taken);
    end

    // A mismatch squashes the whole queue, so a same-cycle push is never stored.
    always_ff @(posedge clock) begin
        if (push && !mismatch) begin
            taken_mem[wr_ptr] <= pred_taken;
            alt_mem[wr_ptr]   <= pred_alt_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= '0;
        end else if (mismatch) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (resolve)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, resolve})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            flush            <= 1'b0;
            redirect_pc      <= '0;
            upd_valid        <= 1'b0;
            upd_taken        <= 1'b0;
            mispredict_count <= '0;
            err_underflow    <= 1'b0;
        end else begin
            flush     <= mismatch;
            upd_valid <= resolve;
            if (resolve)
                upd_taken <= res_taken;
            if (mismatch) begin
                redirect_pc <= head_alt_pc;
                if (mispredict_count != 16'hFFFF)
                    mispredict_count <= mispredict_count + 16'd1;
            end
            if (underflow)
                err_underflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // After a flush the queue is empty, so no back-to-back flush can occur.
    property p_no_double_flush;
        @(posedge clock) disable iff (!resetn) flush |=> !flush;
    endproperty
    assert property (p_no_double_flush);

    property p_occupancy_bound;
        @(posedge clock) disable iff (!resetn) inflight <= CNT_W'(DEPTH);
    endproperty
    assert property (p_occupancy_bound);
`endif

endmodule

// File: tb/tb_z_branch_resolver.sv
// Directed self-checking bench for z_branch_resolver with hand-computed expectations.
module tb_z_branch_resolver;

    localparam int unsigned PC_W  = 12;
    localparam int unsigned DEPTH = 4;

    logic              clock;
    logic              resetn;
    logic              pred_valid;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_alt_pc;
    logic              pred_ready;
    logic              res_valid;
    logic              res_taken;
    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic              upd_valid;
    logic              upd_taken;
    logic [2:0]        inflight;
    logic [15:0]       mispredict_count;
    logic              err_underflow;

    int n_tests;
    int n_fail;

    z_branch_resolver #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_alt_pc      (pred_alt_pc),
        .pred_ready       (pred_ready),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .upd_valid        (upd_valid),
        .upd_taken        (upd_taken),
        .inflight         (inflight),
        .mispredict_count (mispredict_count),
        .err_underflow    (err_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic t, input logic [PC_W-1:0] alt);
        pred_valid  = 1'b1;
        pred_taken  = t;
        pred_alt_pc = alt;
        res_valid   = 1'b0;
        tick();
        idle();
    endtask

    task automatic resolve(input logic t);
        pred_valid = 1'b0;
        res_valid  = 1'b1;
        res_taken  = t;
        tick();
        idle();
    endtask

    // Push a not-taken branch, resolve it taken, then let the flush clear.
    task automatic force_mispredict(input logic [PC_W-1:0] alt);
        push(1'b0, alt);
        resolve(1'b1);
        check("mp_flush", flush, 1);
        check("mp_redirect", redirect_pc, alt);
        tick();
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        resetn      = 1'b0;
        pred_valid  = 1'b0;
        pred_taken  = 1'b0;
        pred_alt_pc = '0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        tick();
        tick();
        check("rst_flush", flush, 0);
        check("rst_redirect", redirect_pc, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_taken", upd_taken, 0);
        check("rst_inflight", inflight, 0);
        check("rst_mcount", mispredict_count, 0);
        check("rst_err", err_underflow, 0);
        check("rst_ready", pred_ready, 1);
        resetn = 1'b1;
        tick();

        // Fill to capacity, then a fifth push must be dropped.
        for (int i = 0; i < 4; i++)
            push(1'b1, 12'h010 + 12'(i));
        check("full_inflight", inflight, 4);
        check("full_ready", pred_ready, 0);
        push(1'b1, 12'h014);
        check("drop_inflight", inflight, 4);

        for (int i = 0; i < 4; i++) begin
            resolve(1'b1);
            check("match_upd_valid", upd_valid, 1);
            check("match_upd_taken", upd_taken, 1);
            check("match_flush", flush, 0);
            check("match_inflight", inflight, 3 - i);
        end
        tick();
        check("idle_upd_valid", upd_valid, 0);

        // Basic misprediction on the oldest entry.
        push(1'b0, 12'h020);
        push(1'b1, 12'h021);
        check("mp1_pre_inflight", inflight, 2);
        resolve(1'b1);
        check("mp1_flush", flush, 1);
        check("mp1_redirect", redirect_pc, 12'h020);
        check("mp1_inflight", inflight, 0);
        check("mp1_mcount", mispredict_count, 1);
        check("mp1_ready", pred_ready, 0);
        check("mp1_upd_valid", upd_valid, 1);
        check("mp1_upd_taken", upd_taken, 1);
        tick();
        check("mp1_flush_clr", flush, 0);
        check("mp1_ready_back", pred_ready, 1);

        // Simultaneous push and resolve: match, then mismatch.
        push(1'b1, 12'h030);
        push(1'b1, 12'h031);
        pred_valid = 1'b1; pred_taken = 1'b1; pred_alt_pc = 12'h032;
        res_valid  = 1'b1; res_taken  = 1'b1;
        tick();
        idle();
        check("sim_match_inflight", inflight, 2);
        check("sim_match_upd_valid", upd_valid, 1);
        check("sim_match_flush", flush, 0);
        pred_valid = 1'b1; pred_taken = 1'b1; pred_alt_pc = 12'h033;
        res_valid  = 1'b1; res_taken  = 1'b0;
        tick();
        idle();
        check("sim_mm_flush", flush, 1);
        check("sim_mm_redirect", redirect_pc, 12'h031);
        check("sim_mm_inflight", inflight, 0);
        check("sim_mm_upd_taken", upd_taken, 0);
        check("sim_mm_mcount", mispredict_count, 2);
        tick();
        check("sim_mm_flush_clr", flush, 0);
        check("sim_mm_inflight2", inflight, 0);
        push(1'b1, 12'h040);
        check("post_mm_inflight", inflight, 1);
        resolve(1'b0);
        check("post_mm_redirect", redirect_pc, 12'h040);
        check("post_mm_mcount", mispredict_count, 3);
        tick();

        // Resolution with nothing in flight.
        check("pre_uf_err", err_underflow, 0);
        resolve(1'b1);
        check("uf_err", err_underflow, 1);
        check("uf_upd_valid", upd_valid, 0);
        check("uf_flush", flush, 0);
        check("uf_inflight", inflight, 0);
        tick();
        tick();
        check("uf_err_sticky", err_underflow, 1);

        // Saturation: preload near the top, then mispredict past it.
        force dut.mispredict_count = 16'hFFFC;
        #1;
        release dut.mispredict_count;
        force_mispredict(12'h051);
        force_mispredict(12'h052);
        check("sat_fffe", mispredict_count, 16'hFFFE);
        force_mispredict(12'h053);
        check("sat_ffff", mispredict_count, 16'hFFFF);
        force_mispredict(12'h054);
        check("sat_hold", mispredict_count, 16'hFFFF);

        // Reset mid-stream overrides a simultaneous push and mismatching resolve.
        push(1'b0, 12'h060);
        push(1'b1, 12'h061);
        resetn     = 1'b0;
        pred_valid = 1'b1; pred_taken = 1'b1; pred_alt_pc = 12'h062;
        res_valid  = 1'b1; res_taken  = 1'b1;
        tick();
        idle();
        check("mrst_flush", flush, 0);
        check("mrst_redirect", redirect_pc, 0);
        check("mrst_upd_valid", upd_valid, 0);
        check("mrst_upd_taken", upd_taken, 0);
        check("mrst_inflight", inflight, 0);
        check("mrst_mcount", mispredict_count, 0);
        check("mrst_err", err_underflow, 0);
        resetn = 1'b1;
        tick();
        check("mrst_ready", pred_ready, 1);
        resolve(1'b1);
        check("mrst_abandoned_err", err_underflow, 1);
        check("mrst_abandoned_upd", upd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z_branch_resolver.md
Z_BRANCH_RESOLVER -- requirements
Module: z_branch_resolver

Interface
REQ-001 Parameter PC_W, default 12: width of every program-counter field.
REQ-002 Parameter DEPTH, default 4 (power of two, 2..16): number of in-flight predicted branches tracked.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low; sampled on the rising edge of clock.
REQ-005 pred_valid  input  1  fetch issues a predicted branch this cycle.
REQ-006 pred_taken  input  1  direction predicted by the branch predictor for that branch.
REQ-007 pred_alt_pc  input  PC_W  recovery PC: the target if predicted not-taken, PC+1 if predicted taken.
REQ-008 pred_ready  output  1  high when a push will be accepted.
REQ-009 res_valid  input  1  execute resolves the oldest in-flight branch this cycle.
REQ-010 res_taken  input  1  actual branch outcome.
REQ-011 flush  output  1  registered one-cycle pulse on misprediction.
REQ-012 redirect_pc  output  PC_W  recovery PC; valid only while flush=1.
REQ-013 upd_valid  output  1  registered one-cycle pulse; drives the predictor's branch_op.
REQ-014 upd_taken  output  1  registered outcome; drives the predictor's branch_taken.
REQ-015 inflight  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 mispredict_count  output  16  saturating misprediction counter.
REQ-017 err_underflow  output  1  sticky flag: resolution arrived with no branch in flight.

Function
REQ-018 The block SHALL hold {pred_taken, pred_alt_pc} entries in a DEPTH-entry circular FIFO with wrap-around read/write pointers and a separate occupancy counter.
REQ-019 pred_ready SHALL equal (inflight < DEPTH) AND NOT flush.
REQ-020 A push (pred_valid AND pred_ready) SHALL write at the tail; a push with pred_ready=0 SHALL be dropped without any state change.
REQ-021 A resolution (res_valid AND inflight>0) SHALL compare res_taken against the head entry's pred_taken and pop the head.
REQ-022 Each resolution SHALL set upd_valid=1 and upd_taken=res_taken in the following cycle; otherwise upd_valid=0.
REQ-023 On a match, flush SHALL be 0 next cycle; a simultaneous push and pop SHALL leave inflight unchanged.
REQ-024 On a mismatch, the next cycle SHALL have flush=1, redirect_pc=head pred_alt_pc, and inflight=0 (all younger entries discarded); a push in the same cycle SHALL be discarded.
REQ-025 Each mismatch SHALL increment mispredict_count by 1, saturating at 16'hFFFF.
REQ-026 res_valid with inflight=0 SHALL change no FIFO or pointer state, SHALL NOT pulse upd_valid or flush, and SHALL set err_underflow=1 until reset.
REQ-027 flush SHALL never be high on two consecutive cycles without a new mismatching resolution between them.
REQ-028 Latency SHALL be exactly one cycle from resolution to flush/upd_valid; the module SHALL contain no combinational path from inputs to flush, redirect_pc, upd_valid or upd_taken.

Reset
REQ-029 While resetn=0 at a clock edge: pointers=0, inflight=0, flush=0, redirect_pc=0, upd_valid=0, upd_taken=0, mispredict_count=0, err_underflow=0.
REQ-030 Reset SHALL take priority over simultaneous push/resolve and SHALL abandon in-flight entries mid-operation.
REQ-031 FIFO storage contents need not be reset.

Verification
REQ-032 Push 4 entries (taken, alt 0x010..0x013) -> inflight=4, pred_ready=0; 5th push dropped; inflight stays 4.
REQ-033 Resolve 4 times with res_taken=1 -> four upd_valid pulses with upd_taken=1, flush never 1, inflight=0.
REQ-034 Push {0,0x020},{1,0x021}; resolve res_taken=1 -> next cycle flush=1, redirect_pc=0x020, inflight=0, mispredict_count=1, pred_ready=0; cycle after, flush=0, pred_ready=1.
REQ-035 With inflight=2, push and matching resolve in the same cycle -> inflight=2, upd_valid=1 next cycle; repeat with mismatching resolve -> inflight=0, pushed entry discarded.
REQ-036 res_valid at inflight=0 -> err_underflow=1, no upd_valid, no flush; err_underflow held until resetn=0 clears it.
REQ-037 Preload mispredict_count to 0xFFFE via 2 mismatches after force, then 2 more -> counter reads 0xFFFF; resetn=0 mid-stream -> all outputs at REQ-029 values next cycle.
